// File: rtl/spi_init_sequencer.sv
// Register-initialisation sequencer: walks a sync-ROM table and drives the SPI register
// master's write/read request ports. It reports either completion or the index of the failing entry.
module spi_init_sequencer #(
    parameter int unsigned INDEX_WIDTH    = 6,
    parameter int unsigned DELAY_UNIT     = 50000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CLOCKS = 4096
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    output logic [INDEX_WIDTH-1:0] o_tableIndex,
    input  logic [17:0]            i_tableEntry,
    output logic                   o_txBegin,
    output logic [6:0]             o_txAddress,
    output logic [7:0]             o_txData,
    input  logic                   i_txBusy,
    input  logic                   i_txDone,
    output logic                   o_rxBegin,
    output logic [6:0]             o_rxAddress,
    input  logic [7:0]             i_rxData,
    input  logic                   i_rxBusy,
    input  logic                   i_rxDone,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [INDEX_WIDTH-1:0] o_errorIndex,
    output logic [7:0]             o_errorData
);

    localparam int unsigned RetryW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CLOCKS + 1);
    localparam int unsigned UnitW    = $clog2(DELAY_UNIT + 1);

    localparam logic [RetryW-1:0]      RetryMax    = RetryW'(MAX_RETRIES);
    localparam logic [TimeoutW-1:0]    TimeoutLast = TimeoutW'(TIMEOUT_CLOCKS - 1);
    localparam logic [UnitW-1:0]       UnitLast    = UnitW'(DELAY_UNIT - 1);
    localparam logic [INDEX_WIDTH-1:0] IndexLast   = '1;

    localparam logic [1:0] OpWrite  = 2'b00;
    localparam logic [1:0] OpVerify = 2'b01;
    localparam logic [1:0] OpDelay  = 2'b10;
    localparam logic [1:0] OpEnd    = 2'b11;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StWrReq, StWrWait,
        StRdReq, StRdWait, StDelay, StDone, StFail
    } state_e;

    state_e                   r_state;
    logic [INDEX_WIDTH-1:0]   r_index;
    logic [1:0]               r_op;
    logic [6:0]               r_addr;
    logic [7:0]               r_data;
    logic [RetryW-1:0]        r_retry;
    logic [TimeoutW-1:0]      r_timeout;
    logic [15:0]              r_ticks;
    logic [UnitW-1:0]         r_unit;
    logic                     r_tx_begin;
    logic [6:0]               r_tx_address;
    logic [7:0]               r_tx_data;
    logic                     r_rx_begin;
    logic [6:0]               r_rx_address;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;
    logic [INDEX_WIDTH-1:0]   r_error_index;
    logic [7:0]               r_error_data;

    logic w_master_idle;
    logic w_advance;
    logic w_timeout;

    // Every path that finishes an entry funnels through w_advance so the end-of-table check lives in one place.
    always_comb begin
        w_master_idle = !i_txBusy && !i_rxBusy;
        w_advance     = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            StWrWait: begin
                w_advance = i_txDone && (r_op == OpWrite);
                w_timeout = !i_txDone && (r_timeout == TimeoutLast);
            end
            StRdWait: begin
                w_advance = i_rxDone && (i_rxData == r_data);
                w_timeout = !i_rxDone && (r_timeout == TimeoutLast);
            end
            StDelay:  w_advance = (r_ticks == 16'd0);
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_index       <= '0;
            r_op          <= 2'b00;
            r_addr        <= '0;
            r_data        <= '0;
            r_retry       <= '0;
            r_timeout     <= '0;
            r_ticks       <= '0;
            r_unit        <= '0;
            r_tx_begin    <= 1'b0;
            r_tx_address  <= '0;
            r_tx_data     <= '0;
            r_rx_begin    <= 1'b0;
            r_rx_address  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_error_index <= '0;
            r_error_data  <= '0;
        end else begin
            r_tx_begin <= 1'b0;
            r_rx_begin <= 1'b0;
            if (w_advance) begin
                r_retry <= '0;
                if (r_index == IndexLast) begin
                    r_state       <= StFail;
                    r_busy        <= 1'b0;
                    r_error       <= 1'b1;
                    r_error_index <= r_index;
                    r_error_data  <= '0;
                end else begin
                    r_index <= r_index + 1'b1;
                    r_state <= StFetch;
                end
            end else if (w_timeout) begin
                r_state       <= StFail;
                r_busy        <= 1'b0;
                r_error       <= 1'b1;
                r_error_index <= r_index;
                r_error_data  <= '0;
            end else begin
                case (r_state)
                    StIdle, StDone, StFail: begin
                        if (i_start) begin
                            r_done        <= 1'b0;
                            r_error       <= 1'b0;
                            r_error_index <= '0;
                            r_error_data  <= '0;
                            r_index       <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= StFetch;
                        end
                    end
                    StFetch: r_state <= StDecode;
                    StDecode: begin
                        r_op    <= i_tableEntry[17:16];
                        r_addr  <= i_tableEntry[14:8];
                        r_data  <= i_tableEntry[7:0];
                        r_retry <= '0;
                        case (i_tableEntry[17:16])
                            OpWrite, OpVerify: r_state <= StWrReq;
                            OpDelay: begin
                                r_ticks <= i_tableEntry[15:0];
                                r_unit  <= '0;
                                r_state <= StDelay;
                            end
                            OpEnd: begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= StDone;
                            end
                        endcase
                    end
                    StWrReq: begin
                        if (w_master_idle) begin
                            r_tx_begin   <= 1'b1;
                            r_tx_address <= r_addr;
                            r_tx_data    <= r_data;
                            r_timeout    <= '0;
                            r_state      <= StWrWait;
                        end
                    end
                    StWrWait: begin
                        if (i_txDone) begin
                            r_state <= StRdReq;
                        end else begin
                            r_timeout <= r_timeout + 1'b1;
                        end
                    end
                    StRdReq: begin
                        if (w_master_idle) begin
                            r_rx_begin   <= 1'b1;
                            r_rx_address <= r_addr;
                            r_timeout    <= '0;
                            r_state      <= StRdWait;
                        end
                    end
                    StRdWait: begin
                        // A matching readback is taken by w_advance, so a done here is a mismatch.
                        if (i_rxDone) begin
                            if (r_retry < RetryMax) begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= StWrReq;
                            end else begin
                                r_state       <= StFail;
                                r_busy        <= 1'b0;
                                r_error       <= 1'b1;
                                r_error_index <= r_index;
                                r_error_data  <= i_rxData;
                            end
                        end else begin
                            r_timeout <= r_timeout + 1'b1;
                        end
                    end
                    StDelay: begin
                        if (r_unit == UnitLast) begin
                            r_unit  <= '0;
                            r_ticks <= r_ticks - 1'b1;
                        end else begin
                            r_unit <= r_unit + 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_tableIndex = r_index;
    assign o_txBegin    = r_tx_begin;
    assign o_txAddress  = r_tx_address;
    assign o_txData     = r_tx_data;
    assign o_rxBegin    = r_rx_begin;
    assign o_rxAddress  = r_rx_address;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_errorIndex = r_error_index;
    assign o_errorData  = r_error_data;

endmodule
